// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store path.
//   MEM_B / MEM_H / MEM_W : MemSize encodings, shared with the control unit.
//   lsu_state_e           : load/store unit FSM state encoding.
//   is_misaligned()       : alignment rule for a given size and low address bits.
package lsu_pkg;

    localparam logic [1:0] MEM_B = 2'b00;
    localparam logic [1:0] MEM_H = 2'b01;
    localparam logic [1:0] MEM_W = 2'b10;

    typedef enum logic [1:0] {
        LSU_IDLE   = 2'b00,
        LSU_ACCESS = 2'b01,
        LSU_RESP   = 2'b10
    } lsu_state_e;

    // Size 2'b11 has no legal alignment, so it always reports misaligned.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        case (size)
            MEM_B:   mis = 1'b0;
            MEM_H:   mis = addr_lo[0];
            MEM_W:   mis = (addr_lo != 2'b00);
            default: mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_lane_formatter.sv
// Combinational byte-lane formatter for the load/store unit.
//   size, addr_lo    : access size and byte offset within the word
//   sign             : sign-extend (1) or zero-extend (0) load data
//   wdata            : store data, value in the low bits
//   rdata            : raw word read from memory
//   be, wdata_lanes  : byte enables and lane-replicated store data
//   rdata_fmt        : extracted and extended load result
//   misaligned       : access cannot be performed as a single aligned word access
module lsu_lane_formatter
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sign,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_lanes,
    output logic [31:0] rdata_fmt,
    output logic        misaligned
);

    // Lane steering for stores and lane extraction/extension for loads.
    always_comb begin
        be          = 4'b0000;
        wdata_lanes = 32'h0000_0000;
        rdata_fmt   = 32'h0000_0000;
        misaligned  = is_misaligned(size, addr_lo);
        case (size)
            MEM_B: begin
                be          = 4'b0001 << addr_lo;
                wdata_lanes = {4{wdata[7:0]}};
                rdata_fmt   = {{24{sign & rdata[{addr_lo, 3'b111}]}}, rdata[{addr_lo, 3'b000} +: 8]};
            end
            MEM_H: begin
                be          = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_lanes = {2{wdata[15:0]}};
                rdata_fmt   = {{16{sign & rdata[{addr_lo[1], 4'b1111}]}}, rdata[{addr_lo[1], 4'b0000} +: 16]};
            end
            MEM_W: begin
                be          = 4'b1111;
                wdata_lanes = wdata;
                rdata_fmt   = rdata;
            end
            default: begin
                be          = 4'b0000;
                wdata_lanes = 32'h0000_0000;
                rdata_fmt   = 32'h0000_0000;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle data-memory stage: IDLE -> ACCESS -> RESP -> IDLE.
//   req_*            : access request from the core (held until done)
//   stall            : freeze PC/regfile while an access is outstanding
//   done             : one-cycle completion pulse, errors and rdata_out valid with it
//   rdata_out        : formatted load result
//   misaligned_err   : access rejected without a bus cycle
//   bus_err          : memory did not respond within TIMEOUT_CYCLES
//   mem_*            : word-wide memory bus with req/ready handshake
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_sign,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata_out,
    output logic        misaligned_err,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    lsu_state_e  state_r, state_nxt_s;
    logic        accept_s, capture_s, expire_s;
    logic        write_r, sign_r;
    logic [1:0]  size_r, addr_lo_r;
    logic [7:0]  cnt_r;
    logic [31:0] mem_addr_r, mem_wdata_r, rdata_r;
    logic [3:0]  mem_be_r;
    logic        done_r, mis_r, bus_r;
    logic [1:0]  fmt_size_s, fmt_addr_s;
    logic [3:0]  fmt_be_s;
    logic [31:0] fmt_wdata_s, fmt_rdata_s;
    logic        fmt_mis_s;

    // In IDLE the formatter looks at the incoming request; afterwards at the latched one.
    always_comb begin
        if (state_r == LSU_IDLE) begin
            fmt_size_s = req_size;
            fmt_addr_s = req_addr[1:0];
        end else begin
            fmt_size_s = size_r;
            fmt_addr_s = addr_lo_r;
        end
    end

    lsu_lane_formatter u_fmt (
        .size        (fmt_size_s),
        .sign        (sign_r),
        .addr_lo     (fmt_addr_s),
        .wdata       (req_wdata),
        .rdata       (mem_rdata),
        .be          (fmt_be_s),
        .wdata_lanes (fmt_wdata_s),
        .rdata_fmt   (fmt_rdata_s),
        .misaligned  (fmt_mis_s)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= LSU_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic and per-cycle event strobes; ready beats timeout on the same cycle.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        capture_s   = 1'b0;
        expire_s    = 1'b0;
        case (state_r)
            LSU_IDLE: begin
                if (req_valid) begin
                    accept_s    = 1'b1;
                    state_nxt_s = fmt_mis_s ? LSU_RESP : LSU_ACCESS;
                end else begin
                    state_nxt_s = LSU_IDLE;
                end
            end
            LSU_ACCESS: begin
                if (mem_ready) begin
                    capture_s   = 1'b1;
                    state_nxt_s = LSU_RESP;
                end else if (cnt_r == TIMEOUT_LAST) begin
                    expire_s    = 1'b1;
                    state_nxt_s = LSU_RESP;
                end else begin
                    state_nxt_s = LSU_ACCESS;
                end
            end
            LSU_RESP: begin
                state_nxt_s = LSU_IDLE;
            end
            default: begin
                state_nxt_s = LSU_IDLE;
            end
        endcase
    end

    // Request latches, bus drive registers, result/error registers and wait counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            write_r     <= 1'b0;
            sign_r      <= 1'b0;
            size_r      <= 2'b00;
            addr_lo_r   <= 2'b00;
            mem_addr_r  <= 32'h0000_0000;
            mem_be_r    <= 4'b0000;
            mem_wdata_r <= 32'h0000_0000;
            rdata_r     <= 32'h0000_0000;
            done_r      <= 1'b0;
            mis_r       <= 1'b0;
            bus_r       <= 1'b0;
            cnt_r       <= 8'h00;
        end else begin
            done_r <= (state_nxt_s == LSU_RESP);
            if (accept_s) begin
                write_r     <= req_write;
                sign_r      <= req_sign;
                size_r      <= req_size;
                addr_lo_r   <= req_addr[1:0];
                mem_addr_r  <= {req_addr[31:2], 2'b00};
                mem_be_r    <= fmt_be_s;
                mem_wdata_r <= fmt_wdata_s;
                mis_r       <= fmt_mis_s;
                bus_r       <= 1'b0;
                rdata_r     <= 32'h0000_0000;
            end else if (capture_s) begin
                rdata_r <= write_r ? 32'h0000_0000 : fmt_rdata_s;
            end else if (expire_s) begin
                bus_r <= 1'b1;
            end else begin
                rdata_r <= rdata_r;
            end
            // Counts wait states only while the access stays outstanding.
            if ((state_r == LSU_ACCESS) && (state_nxt_s == LSU_ACCESS)) begin
                cnt_r <= cnt_r + 8'd1;
            end else begin
                cnt_r <= 8'h00;
            end
        end
    end

    // mem_req decodes the state register directly so reset removes it immediately.
    assign mem_req        = (state_r == LSU_ACCESS);
    assign mem_we         = mem_req & write_r;
    assign mem_addr       = mem_addr_r;
    assign mem_be         = mem_be_r;
    assign mem_wdata      = mem_wdata_r;
    assign stall          = req_valid & (state_r != LSU_RESP);
    assign done           = done_r;
    assign rdata_out      = rdata_r;
    assign misaligned_err = mis_r;
    assign bus_err        = bus_r;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_write, req_sign;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        stall, done, misaligned_err, bus_err;
    logic [31:0] rdata_out;
    logic        mem_req, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    int vectors = 0;
    int miscompares = 0;

    load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_write      (req_write),
        .req_size       (req_size),
        .req_sign       (req_sign),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .stall          (stall),
        .done           (done),
        .rdata_out      (rdata_out),
        .misaligned_err (misaligned_err),
        .bus_err        (bus_err),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_be         (mem_be),
        .mem_wdata      (mem_wdata),
        .mem_ready      (mem_ready),
        .mem_rdata      (mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: alignment rule, byte enables, store lanes, load extraction.
    function automatic logic model_mis(input logic [1:0] sz, input logic [31:0] a);
        int unsigned align;
        if (sz == 2'd3) return 1'b1;
        align = 32'd1 << sz;
        return (a % align) != 0;
    endfunction

    function automatic logic [31:0] model_be(input logic [1:0] sz, input logic [31:0] a);
        int unsigned off;
        off = a % 4;
        case (sz)
            2'd0:    return 32'd1 << off;
            2'd1:    return (off >= 2) ? 32'hC : 32'h3;
            default: return 32'hF;
        endcase
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] wd);
        case (sz)
            2'd0:    return (wd & 32'hFF) * 32'h0101_0101;
            2'd1:    return (wd & 32'hFFFF) * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] sz, input logic sg,
                                               input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] v;
        int unsigned off;
        off = a % 4;
        case (sz)
            2'd0: begin
                v = (rd >> (8 * off)) & 32'hFF;
                if (sg && v >= 32'd128) v = v | 32'hFFFF_FF00;
            end
            2'd1: begin
                v = (rd >> (16 * (off / 2))) & 32'hFFFF;
                if (sg && v >= 32'd32768) v = v | 32'hFFFF_0000;
            end
            default: v = rd;
        endcase
        return v;
    endfunction

    // One complete access: ws wait cycles before mem_ready (ws >= TO never answers).
    task automatic do_access(input logic wr, input logic [1:0] sz, input logic sg,
                             input logic [31:0] a, input logic [31:0] wd,
                             input int ws, input logic [31:0] rd);
        logic        mis;
        logic        tmo;
        logic [31:0] exp_rd;
        mis = model_mis(sz, a);
        tmo = !mis && (ws >= TO);
        exp_rd = (mis || tmo || wr) ? 32'h0 : model_load(sz, sg, a, rd);
        req_valid = 1'b1;
        req_write = wr;
        req_size  = sz;
        req_sign  = sg;
        req_addr  = a;
        req_wdata = wd;
        mem_ready = 1'b0;
        mem_rdata = $urandom;
        #1;
        chk("stall_accept", 32'(stall), 32'h1);
        step();
        if (!mis) begin
            for (int n = 0; n < TO; n++) begin
                chk("mem_req", 32'(mem_req), 32'h1);
                chk("mem_we", 32'(mem_we), 32'(wr));
                chk("mem_addr", mem_addr, a & 32'hFFFF_FFFC);
                chk("mem_be", 32'(mem_be), model_be(sz, a));
                if (wr) chk("mem_wdata", mem_wdata, model_wdata(sz, wd));
                chk("stall_access", 32'(stall), 32'h1);
                chk("done_early", 32'(done), 32'h0);
                if (n == ws) begin
                    mem_ready = 1'b1;
                    mem_rdata = rd;
                end
                step();
                if (n == ws) break;
            end
        end
        chk("done", 32'(done), 32'h1);
        chk("misaligned_err", 32'(misaligned_err), 32'(mis));
        chk("bus_err", 32'(bus_err), 32'(tmo));
        chk("rdata_out", rdata_out, exp_rd);
        chk("mem_req_resp", 32'(mem_req), 32'h0);
        chk("stall_resp", 32'(stall), 32'h0);
        req_valid = 1'b0;
        mem_ready = 1'b0;
        step();
        chk("done_pulse", 32'(done), 32'h0);
        chk("mem_req_idle", 32'(mem_req), 32'h0);
    endtask

    initial begin
        logic        rwr, rsg;
        logic [1:0]  rsz;
        logic [31:0] raddr, rwd, rrd;
        int          rws;

        rst       = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_size  = 2'b00;
        req_sign  = 1'b0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        #2;
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_mis", 32'(misaligned_err), 32'h0);
        chk("rst_bus", 32'(bus_err), 32'h0);
        chk("rst_rdata", rdata_out, 32'h0);
        chk("rst_mem_req", 32'(mem_req), 32'h0);
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_be", 32'(mem_be), 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        req_valid = 1'b1;
        #1;
        chk("rst_stall_follows", 32'(stall), 32'h1);
        req_valid = 1'b0;
        step();
        rst = 1'b0;
        step();

        // Directed cases.
        do_access(1'b1, 2'd0, 1'b0, 32'h0000_1003, 32'h0000_00A5, 0, 32'h0);
        do_access(1'b0, 2'd0, 1'b1, 32'h0000_2002, 32'h0, 0, 32'h12F0_3456);
        do_access(1'b0, 2'd0, 1'b0, 32'h0000_2002, 32'h0, 0, 32'h12F0_3456);
        do_access(1'b0, 2'd1, 1'b1, 32'h0000_3001, 32'h0, 0, 32'h0);
        do_access(1'b0, 2'd2, 1'b0, 32'h0000_4000, 32'h0, 5, 32'hCAFE_BABE);
        do_access(1'b0, 2'd2, 1'b0, 32'h0000_4100, 32'h0, TO, 32'h1234_5678);
        do_access(1'b0, 2'd2, 1'b0, 32'h0000_4200, 32'h0, TO - 1, 32'h1234_5678);
        do_access(1'b1, 2'd1, 1'b0, 32'h0000_5002, 32'hDEAD_BEEF, 1, 32'h0);
        do_access(1'b0, 2'd1, 1'b1, 32'h0000_5002, 32'h0, 0, 32'h8001_7FFF);
        do_access(1'b0, 2'd1, 1'b0, 32'h0000_5000, 32'h0, 2, 32'h8001_F00F);
        do_access(1'b1, 2'd3, 1'b0, 32'h0000_6000, 32'h0, 0, 32'h0);
        do_access(1'b1, 2'd2, 1'b0, 32'h0000_6002, 32'h0, 0, 32'h0);

        // Reset in the middle of an access.
        req_valid = 1'b1;
        req_write = 1'b0;
        req_size  = 2'd2;
        req_addr  = 32'h0000_7000;
        mem_ready = 1'b0;
        step();
        chk("mid_mem_req", 32'(mem_req), 32'h1);
        step();
        rst = 1'b1;
        #1;
        chk("mid_rst_mem_req", 32'(mem_req), 32'h0);
        chk("mid_rst_done", 32'(done), 32'h0);
        chk("mid_rst_bus", 32'(bus_err), 32'h0);
        chk("mid_rst_mis", 32'(misaligned_err), 32'h0);
        req_valid = 1'b0;
        #2;
        rst = 1'b0;
        step();
        chk("post_rst_mem_req", 32'(mem_req), 32'h0);
        chk("post_rst_done", 32'(done), 32'h0);
        do_access(1'b1, 2'd2, 1'b0, 32'h0000_8004, 32'h1122_3344, 1, 32'h0);

        // Randomized accesses, back to back.
        for (int i = 0; i < 60; i++) begin
            rwr   = 1'($urandom_range(1, 0));
            rsg   = 1'($urandom_range(1, 0));
            rsz   = 2'($urandom_range(3, 0));
            raddr = $urandom;
            rwd   = $urandom;
            rrd   = $urandom;
            rws   = int'($urandom_range(TO + 1, 0));
            do_access(rwr, rsz, rsg, raddr, rwd, rws, rrd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
